// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory-side posted-write buffer.
package mips_mem_pkg;

  localparam int unsigned WbAw = 32;
  localparam int unsigned WbDw = 32;

  typedef struct packed {
    logic            valid;
    logic [WbAw-1:0] addr;
    logic [WbDw-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } wbstate_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular store buffer: head/tail pointers, occupancy and a per-entry word-address compare.
module wb_fifo
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WbAw,
  parameter int unsigned DW    = WbDw,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_addr_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  input  logic [AW-1:2]          cmp_word_i,
  output wb_entry_t              head_o,
  output wb_entry_t              next_o,
  output logic [DEPTH-1:0]       match_o,
  output logic [DEPTH-1:0][DW-1:0] data_o,
  output logic [PtrW-1:0]        head_ptr_o,
  output logic [CntW-1:0]        count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q, next_ptr;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o   = (count_q == CntW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign next_ptr = head_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
        tail_q        <= tail_q + 1'b1;
      end
      // Push and pop never address the same slot: that needs full or empty.
      if (do_pop) begin
        mem_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match_o[i] = mem_q[i].valid && (mem_q[i].addr[AW-1:2] == cmp_word_i);
    assign data_o[i]  = mem_q[i].data;
  end

  assign head_o     = mem_q[head_q];
  assign next_o     = mem_q[next_ptr];
  assign head_ptr_o = head_q;
  assign count_o    = count_q;

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the multicycle MIPS core and unified memory, with load forwarding.
module mem_write_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WbAw,
  parameter int unsigned DW    = WbDw,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cpu_memwrite_i,
  input  logic            cpu_memread_i,
  input  logic [AW-1:0]   cpu_addr_i,
  input  logic [DW-1:0]   cpu_writedata_i,
  output logic [DW-1:0]   cpu_readdata_o,
  output logic            cpu_stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  wbstate_t                state_q;
  logic                    mem_req_q, mem_we_q;
  logic [AW-1:0]           mem_addr_q;
  logic [DW-1:0]           mem_wdata_q;

  wb_entry_t               head, next;
  logic [DEPTH-1:0]        match;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [PtrW-1:0]         head_ptr, idx;
  logic                    store_go, load_req, hit, load_hit, load_miss;
  logic                    read_done, drain_done;
  logic [DW-1:0]           hit_data;

  wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (cpu_memwrite_i),
    .push_addr_i(cpu_addr_i),
    .push_data_i(cpu_writedata_i),
    .pop_i      (drain_done),
    .cmp_word_i (cpu_addr_i[AW-1:2]),
    .head_o     (head),
    .next_o     (next),
    .match_o    (match),
    .data_o     (ent_data),
    .head_ptr_o (head_ptr),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  // A write in the same cycle as a read wins; the read is ignored.
  assign store_go   = cpu_memwrite_i && !full_o;
  assign load_req   = cpu_memread_i && !cpu_memwrite_i;
  assign load_hit   = load_req && hit;
  assign load_miss  = load_req && !hit;
  assign read_done  = (state_q == StRead) && mem_ack_i;
  assign drain_done = (state_q == StDrain) && mem_ack_i;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PtrW'(k);
      if (match[idx]) begin
        hit      = 1'b1;
        hit_data = ent_data[idx];
      end
    end
  end

  always_comb begin
    cpu_stall_o    = (cpu_memwrite_i && full_o) || (load_miss && !read_done);
    cpu_readdata_o = '0;
    if (load_hit) begin
      cpu_readdata_o = hit_data;
    end else if (load_miss && read_done) begin
      cpu_readdata_o = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_miss) begin
            state_q    <= StRead;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= cpu_addr_i;
          end else if (head.valid) begin
            state_q     <= StDrain;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= head.addr;
            mem_wdata_q <= head.data;
          end else if (store_go) begin
            // Empty buffer: the store being enqueued now is the head next cycle.
            state_q     <= StDrain;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cpu_addr_i;
            mem_wdata_q <= cpu_writedata_i;
          end
        end
        StRead: begin
          if (mem_ack_i) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end
        end
        StDrain: begin
          if (mem_ack_i) begin
            if (load_miss) begin
              state_q    <= StRead;
              mem_we_q   <= 1'b0;
              mem_addr_q <= cpu_addr_i;
            end else if (next.valid) begin
              mem_addr_q  <= next.addr;
              mem_wdata_q <= next.data;
            end else begin
              state_q   <= StIdle;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
Posted-write buffer between the multicycle MIPS core's memory port (addr/writedata/memwrite) and the unified instruction/data memory. CPU stores retire into a small FIFO in one cycle, and the buffer drains them to memory over a req/ack handshake. Loads check the buffer first and forward the youngest matching store. Loads that miss go to memory ahead of pending drains.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >=2
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_memwrite  in  1  store request, one word
cpu_memread  in  1  load request
cpu_addr  in  AW  byte address; bits [1:0] ignored (word accesses only)
cpu_writedata  in  DW  store data
cpu_readdata  out  DW  load data, valid when cpu_memread=1 and cpu_stall=0
cpu_stall  out  1  CPU must hold its request and not advance
mem_req  out  1  memory transaction request
mem_we  out  1  1=write, 0=read; valid while mem_req=1
mem_addr  out  AW  memory address; valid while mem_req=1
mem_wdata  out  DW  memory write data
mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle
mem_rdata  in  DW  memory read data
count  out  $clog2(DEPTH+1)  occupied entries
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (reset=0, async):
  - FIFO pointers, count, and the valid bits cleared; buffered stores are discarded.
  - FSM goes to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_readdata=0, full=0, empty=1.
- Store:
  - If cpu_memwrite=1 and not full, the entry is enqueued at the rising edge with cpu_stall=0 (single-cycle retire).
  - If full, cpu_stall=1 and nothing is enqueued. Stall is based on full only; it does not bypass on a same-cycle drain ack.
- Load hit:
  - Hit when cpu_memread=1 and any valid entry has entry_addr[AW-1:2]==cpu_addr[AW-1:2].
  - cpu_readdata is the youngest matching entry, combinationally; cpu_stall=0; no memory access.
- Load miss:
  - cpu_stall=1 until memory completes the read.
  - In the ack cycle: cpu_readdata=mem_rdata and cpu_stall=0.
- cpu_memread and cpu_memwrite both 1 in the same cycle is illegal; the bench asserts on it. The RTL gives cpu_memwrite priority.
- FSM (state registered):
  - IDLE:
    - A load miss goes to READ (mem_req=1, mem_we=0, mem_addr=cpu_addr) in the next cycle.
    - Otherwise, if not empty, go to DRAIN with the head entry.
    - A load miss has priority over a drain.
  - READ: hold mem_req/mem_addr stable until mem_ack, then return to IDLE.
  - DRAIN:
    - Hold mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry until mem_ack.
    - On ack, dequeue the head.
    - If a load miss is pending, go to READ; else if count>1, stay in DRAIN with the next head; else go to IDLE.
    - An in-flight drain is never aborted.
- Enqueue and dequeue in the same cycle: count is unchanged; both pointers advance; pointers wrap modulo DEPTH.
- A store to an address already buffered is enqueued as a new entry (no merging). Memory ordering between stores is preserved FIFO.
- mem_ack outside READ/DRAIN is ignored.
- Reset asserted mid-transaction: mem_req drops immediately (async); the memory side tolerates the abandoned request.

Decomposition:
- Shared package mips_mem_pkg: wb_entry_t struct {valid, addr[AW-1:0], data[DW-1:0]}; wbstate_t enum {IDLE, READ, DRAIN}.
- Sub-module wb_fifo: circular storage, head/tail pointers, count/full/empty, parallel compare outputs.
- mem_write_buffer holds the FSM and the youngest-match priority select.

Test Plan:
1. Store 7 to addr 84 with mem_ack returned 2 cycles after mem_req -> cpu_stall=0 in the store cycle; count=1; next cycle mem_req=1, mem_we=1, mem_addr=84, mem_wdata=7 held until ack; then count=0, empty=1.
2. Stores 1,2,3,4 to addrs 0,4,8,12 with mem_ack held low, then a 5th store to 16 -> full=1 and cpu_stall=1 on the 5th. After one ack, the 5th is accepted, and drain order to memory is 0,4,8,12,16.
3. Store 5 to 80, then store 9 to 80, then load 80 before any ack -> cpu_readdata=9 with cpu_stall=0 and no mem_req with mem_we=0.
4. Two buffered stores to 0 and 4, load miss at 200 with mem_rdata=0xDEAD -> the in-flight drain of 0 completes, then a READ of 200 precedes the drain of 4. cpu_readdata=0xDEAD in the ack cycle, and stall is released.
5. Three stores buffered, reset pulled low mid-DRAIN -> mem_req=0 immediately, count=0, empty=1. After release, no further memory writes are issued.
6. Pointer wrap: 10 back-to-back stores with mem_ack every cycle -> FIFO order preserved across wrap, and count never exceeds DEPTH.
